// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/multu_seq_twos_neg.sv
// Two's-complement negate, purely combinational.
// Latency: 0 cycles. Backpressure: none, output follows input.
module twos_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = ~din + W'(1);

endmodule

// File: rtl/multu_seq.sv
// Shift-add multiplier for MULT/MULTU, one multiplier bit per clock, signed via magnitudes.
// Latency: result and done pulse WIDTH+1 cycles after the accepting edge.
// Backpressure: ena is ignored while busy; caller stalls on busy.
module multu_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             sgn,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state, state_nxt;
  logic               start;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_mag;
  logic               neg;

  logic [WIDTH-1:0]   a_neg, b_neg, a_sel, b_sel;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH:0]     step_sum;
  logic               last_step;

  twos_neg #(.W(WIDTH))   u_neg_a (.din(multiplicand),        .dout(a_neg));
  twos_neg #(.W(WIDTH))   u_neg_b (.din(multiplier),          .dout(b_neg));
  twos_neg #(.W(2*WIDTH)) u_neg_p (.din(acc[2*WIDTH-1:0]),    .dout(prod_neg));

  // Negating the most negative value yields itself, which is the correct unsigned magnitude.
  assign a_sel = (sgn && multiplicand[WIDTH-1]) ? a_neg : multiplicand;
  assign b_sel = (sgn && multiplier[WIDTH-1])   ? b_neg : multiplier;

  assign step_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (ena) begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last_step) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc   <= '0;
      cnt   <= '0;
      a_mag <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_mag <= a_sel;
          neg   <= sgn & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc   <= {{(WIDTH+1){1'b0}}, b_sel};
          cnt   <= '0;
        end
        RUN: begin
          // Add into the top WIDTH+1 bits, then shift the whole accumulator right by one.
          acc <= {1'b0, step_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          {hi, lo} <= neg ? prod_neg : acc[2*WIDTH-1:0];
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed vector table, randomized model compare, multi-cycle corners.
module tb_multu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        sgn;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  multu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ena(ena), .sgn(sgn),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Starts one operation and waits for done; lat counts edges after the accepting edge.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    res      = '0;
    @(negedge clk);
    ena = 1'b1; sgn = s; multiplicand = a; multiplier = b;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        res = {hi, lo};
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic [63:0] res;
    int          lat, bc, dcnt, first;
    logic        rs;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[3] = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
    vecs[4] = '{1'b1, 32'h80000000,   32'd1,          32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000};
    vecs[6] = '{1'b1, 32'd0,          32'hFFFFFFFF,   32'h00000000, 32'h00000000};

    reset = 1'b0; ena = 1'b0; sgn = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0 + 96'd0);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, res, lat, bc);
      check($sformatf("vec%0d_product", i), res, {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
    end
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h7FFFFFFF;
      if (i == 1) rb = 32'h80000000;
      do_op(rs, ra, rb, res, lat, bc);
      check($sformatf("rand%0d_s%0d_%h_%h", i, rs, ra, rb), res, ref_mul(rs, ra, rb));
    end

    // ena during RUN must be ignored
    @(negedge clk);
    ena = 1'b1; sgn = 1'b0; multiplicand = 32'd7; multiplier = 32'd6;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    dcnt = 0; first = -1; res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 9)  begin ena = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; end
      if (k == 10) ena = 1'b0;
      if (done) begin
        dcnt++;
        if (first < 0) begin first = k; res = {hi, lo}; end
      end
    end
    check("busy_ena_done_count", 64'(dcnt), 64'd1);
    check("busy_ena_latency", 64'(first), 64'd33);
    check("busy_ena_product", res, 64'd42);

    // reset mid-operation
    @(negedge clk);
    ena = 1'b1; sgn = 1'b0; multiplicand = 32'd1000; multiplier = 32'd1000;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    dcnt = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 19) reset = 1'b0;
      if (k == 20) begin
        check("abort_outputs", {30'd0, busy, done, hi, lo}, 64'd0 + 96'd0);
        reset = 1'b1;
      end
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    do_op(1'b0, 32'd2, 32'd2, res, lat, bc);
    check("after_abort_product", res, 64'd4);
    check("after_abort_latency", 64'(lat), 64'd33);

    // back-to-back: second start issued in the done cycle
    do_op(1'b0, 32'd4, 32'd4, res, lat, bc);
    check("b2b_first_product", res, 64'd16);
    check("b2b_first_latency", 64'(lat), 64'd33);
    ena = 1'b1; sgn = 1'b0; multiplicand = 32'd5; multiplier = 32'd5;
    first = -1; res = '0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 1) ena = 1'b0;
      if (done) begin first = j; res = {hi, lo}; break; end
    end
    check("b2b_spacing", 64'(first), 64'd34);
    check("b2b_second_product", res, 64'd25);

    check("busy_done_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multu_seq.md
# multu_seq

Sequential shift-add multiplier for the CPU's MULT/MULTU path, the arithmetic counterpart to the divide unit. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, at one multiplier bit per clock. Results go to the HI/LO register pair. It sits beside the divider in the execute stage, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width; product is 2·WIDTH bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `ena`  in  1  start request; sampled only in IDLE.
- `sgn`  in  1  1 = signed (MULT), 0 = unsigned (MULTU); latched with `ena`.
- `multiplicand`  in  WIDTH  operand A; latched with `ena`.
- `multiplier`  in  WIDTH  operand B; latched with `ena`.
- `busy`  out  1  high while an operation is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when `hi`/`lo` carry a new result.
- `hi`  out  WIDTH  upper product half.
- `lo`  out  WIDTH  lower product half.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `ena`=1:
  - Latch operands and `sgn`.
  - If `sgn`, replace each operand by its magnitude and record `neg` = signA XOR signB. Otherwise `neg`=0.
  - Load `acc` = {(WIDTH+1)'b0, |B|}, set `cnt`=0, go to RUN.
  - |0x80000000| = 0x80000000 as unsigned.
- RUN, each cycle:
  - If `acc[0]`, then `acc[2W:W]` += |A| (WIDTH+1-bit add, carry kept).
  - Shift `acc` right by 1 and increment `cnt`.
  - After the WIDTH-th step, go to FIX.
- FIX:
  - `{hi,lo}` ← `neg` ? two's-complement negate of `acc[2W-1:0]` : `acc[2W-1:0]`.
  - `done`←1, go to IDLE.
- `done` is registered and high for exactly one cycle.
- `hi`/`lo` hold the last result until the next FIX.
- `ena` while `busy`: ignored. The operation in flight and its latched operands are unaffected.
- `ena` in the cycle `done` is high: accepted, because state is already IDLE. Back-to-back operation is legal.
- Fixed latency regardless of operand values. No early-out on zero.
- Reset (`reset`=0), including mid-operation:
  - State → IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `acc`=0, `cnt`=0.
  - The aborted operation produces no `done`.

## Timing
- Edge E0: `ena` accepted. `busy`=1 from E0 onward.
- Edges E1..E(WIDTH): RUN steps. E32 for WIDTH=32.
- Edge E(WIDTH+1): FIX.
  - `hi`/`lo` updated, `done`=1, `busy`=0 after this edge.
- Latency: result visible WIDTH+1 = 33 cycles after the accepting edge. Throughput: one product per 34 cycles, counting back-to-back starts.
- `busy` and `done` are never high simultaneously.

## Structure
- Shared package `mul_pkg`:
  - state enum (IDLE/RUN/FIX),
  - default `WIDTH`,
  - `CNT_W` = $clog2(WIDTH)+1.
- One natural sub-module: `twos_neg`, a combinational parameterised negate. It is instantiated for the operand-magnitude step at width WIDTH and the result-negate step at width 2·WIDTH.
- All other logic stays in `multu_seq`: FSM, counter, accumulator, output registers.
- RTL estimate: about 150 lines.

## Test plan
- Unsigned 3 × 5 → `hi`=0x00000000, `lo`=0x0000000F. `done` pulses exactly 33 cycles after the `ena` edge, for 1 cycle. `busy` is high for the 33 intervening cycles.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed cases:
  - −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
  - 0x80000000 × 1 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- Start 7 × 6, then pulse `ena` with 9 × 9 at RUN step 10 → single `done` with `lo`=42 at the normal time; 9 × 9 never executes.
- Start 1000 × 1000, assert `reset`=0 at RUN step 20 → next cycle `busy`=0, `done`=0, `hi`=`lo`=0. No `done` follows. A subsequent 2 × 2 gives `lo`=4.
- Back-to-back: 4 × 4 → `lo`=16. `ena` with 5 × 5 held high during its `done` cycle → `lo`=25 with `done` 34 cycles after the first.
